// File: rtl/axi4_pkg.sv
// ---------------------------------------------------------------------------
// axi4_pkg
// Shared AXI4 field widths, burst/response encodings and FSM state types for
// the burst SRAM responder and its address generator.
// ---------------------------------------------------------------------------
package axi4_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int STRB_W  = 4;
  localparam int ID_W    = 4;
  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int RESP_W  = 2;

  localparam logic [BURST_W-1:0] BURST_FIXED = 2'b00;
  localparam logic [BURST_W-1:0] BURST_INCR  = 2'b01;
  localparam logic [BURST_W-1:0] BURST_WRAP  = 2'b10;
  localparam logic [BURST_W-1:0] BURST_RSVD  = 2'b11;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

  // Largest transfer size a 32-bit data bus can carry (4 bytes -> size 2).
  localparam logic [SIZE_W-1:0] MAX_SIZE = 3'd2;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  // WRAP bursts are only legal for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [LEN_W-1:0] len);
    logic ok;
    case (len)
      8'd1, 8'd3, 8'd7, 8'd15: ok = 1'b1;
      default:                 ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/axi4_addr_gen.sv
// ---------------------------------------------------------------------------
// axi4_addr_gen
// Combinational AXI4 beat address sequencer. Given the address of the current
// beat and the burst descriptor, produces the address of the following beat
// and flags descriptors this slave cannot honour.
// Ports:
//   addr      in  32  address of the current beat
//   len       in  8   burst length minus one
//   size      in  3   log2 of bytes per beat
//   burst     in  2   FIXED / INCR / WRAP (reserved encoding handled as INCR)
//   next_addr out 32  address of the following beat
//   illegal   out 1   size wider than the bus, reserved burst, or bad WRAP len
// ---------------------------------------------------------------------------
module axi4_addr_gen
  import axi4_pkg::*;
(
  input  logic [ADDR_W-1:0]  addr,
  input  logic [LEN_W-1:0]   len,
  input  logic [SIZE_W-1:0]  size,
  input  logic [BURST_W-1:0] burst,
  output logic [ADDR_W-1:0]  next_addr,
  output logic               illegal
);

  logic [ADDR_W-1:0] incr_s;
  logic [ADDR_W-1:0] sum_s;
  logic [ADDR_W-1:0] wrap_mask_s;

  // Step size, incremented address and wrap window mask.
  always_comb begin
    incr_s      = 32'd1 << size;
    sum_s       = addr + incr_s;
    // Window is (len+1) beats of 2^size bytes; for legal WRAP lengths this is
    // a power of two, so window-1 is a clean low-bit mask.
    wrap_mask_s = (({24'd0, len} + 32'd1) << size) - 32'd1;
  end

  // Next-beat address selection by burst type.
  always_comb begin
    next_addr = sum_s;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = sum_s;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask_s) | (sum_s & wrap_mask_s);
      default:     next_addr = sum_s;
    endcase
  end

  // Descriptor legality.
  always_comb begin
    illegal = 1'b0;
    if (size > MAX_SIZE) begin
      illegal = 1'b1;
    end else if (burst == BURST_RSVD) begin
      illegal = 1'b1;
    end else if ((burst == BURST_WRAP) && !wrap_len_ok(len)) begin
      illegal = 1'b1;
    end else begin
      illegal = 1'b0;
    end
  end

endmodule

// File: rtl/axi4_burst_sram_slave.sv
// ---------------------------------------------------------------------------
// axi4_burst_sram_slave
// AXI4 responder in front of a DEPTH_WORDS x 32 word SRAM. Independent read
// and write FSMs, FIXED/INCR/WRAP bursts, byte strobes, RD_LAT wait cycles
// between AR acceptance and the first R beat, and SLVERR for out-of-range
// beats or unsupported burst descriptors. One transaction per channel at a
// time; all outputs are registered.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   aw*  (awready out)           write address channel
//   w*   (wready out)            write data channel
//   b*   (bvalid/bresp/bid out)  write response channel
//   ar*  (arready out)           read address channel
//   r*   (rvalid/rresp/rdata/rlast/rid out)  read data channel
// ---------------------------------------------------------------------------
module axi4_burst_sram_slave
  import axi4_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          RD_LAT      = 1
) (
  input  logic               clk,
  input  logic               rst,
  output logic               awready,
  input  logic               awvalid,
  input  logic [ADDR_W-1:0]  awaddr,
  input  logic [ID_W-1:0]    awid,
  input  logic [LEN_W-1:0]   awlen,
  input  logic [SIZE_W-1:0]  awsize,
  input  logic [BURST_W-1:0] awburst,
  output logic               wready,
  input  logic               wvalid,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [STRB_W-1:0]  wstrb,
  input  logic               wlast,
  input  logic               bready,
  output logic               bvalid,
  output logic [RESP_W-1:0]  bresp,
  output logic [ID_W-1:0]    bid,
  output logic               arready,
  input  logic               arvalid,
  input  logic [ADDR_W-1:0]  araddr,
  input  logic [ID_W-1:0]    arid,
  input  logic [LEN_W-1:0]   arlen,
  input  logic [SIZE_W-1:0]  arsize,
  input  logic [BURST_W-1:0] arburst,
  input  logic               rready,
  output logic               rvalid,
  output logic [RESP_W-1:0]  rresp,
  output logic [DATA_W-1:0]  rdata,
  output logic               rlast,
  output logic [ID_W-1:0]    rid
);

  localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  LAT_LAST   = (RD_LAT > 0) ? 4'(RD_LAT - 1) : 4'd0;

  // Addresses below BASE_ADDR wrap to a huge offset and fail the same test.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a - BASE_ADDR) < SPAN_BYTES;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  logic [DATA_W-1:0] mem_r [DEPTH_WORDS];

  // ------------------------------------------------------------ write side
  wr_state_e          w_state_r, w_next_s;
  logic [ADDR_W-1:0]  w_addr_r;
  logic [ID_W-1:0]    w_id_r;
  logic [LEN_W-1:0]   w_len_r, w_cnt_r;
  logic [SIZE_W-1:0]  w_size_r;
  logic [BURST_W-1:0] w_burst_r;
  logic               w_err_r;
  logic [RESP_W-1:0]  bresp_r;
  logic               awready_r, wready_r, bvalid_r;
  logic               awready_nxt_s, wready_nxt_s, bvalid_nxt_s;
  logic [ADDR_W-1:0]  w_next_addr_s;
  logic               w_illegal_s;
  logic               aw_fire_s, w_fire_s, b_fire_s, w_is_last_s, w_beat_err_s;

  axi4_addr_gen u_w_addr_gen (
    .addr      (w_addr_r),
    .len       (w_len_r),
    .size      (w_size_r),
    .burst     (w_burst_r),
    .next_addr (w_next_addr_s),
    .illegal   (w_illegal_s)
  );

  assign aw_fire_s   = awvalid & awready_r;
  assign w_fire_s    = wvalid & wready_r;
  assign b_fire_s    = bvalid_r & bready;
  assign w_is_last_s = (w_cnt_r == w_len_r);
  // A wlast that disagrees with the beat count poisons the burst but does
  // not cut it short: the burst always runs the full len+1 beats.
  assign w_beat_err_s = w_illegal_s | ~in_range(w_addr_r) | (wlast != w_is_last_s);

  // Write FSM state and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_r <= W_IDLE;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
    end else begin
      w_state_r <= w_next_s;
      awready_r <= awready_nxt_s;
      wready_r  <= wready_nxt_s;
      bvalid_r  <= bvalid_nxt_s;
    end
  end

  // Write FSM next-state logic.
  always_comb begin
    w_next_s = w_state_r;
    case (w_state_r)
      W_IDLE: begin
        if (aw_fire_s) w_next_s = W_DATA;
        else           w_next_s = W_IDLE;
      end
      W_DATA: begin
        if (w_fire_s && w_is_last_s) w_next_s = W_RESP;
        else                         w_next_s = W_DATA;
      end
      W_RESP: begin
        if (b_fire_s) w_next_s = W_IDLE;
        else          w_next_s = W_RESP;
      end
      default: w_next_s = W_IDLE;
    endcase
  end

  // Write handshake outputs follow the state being entered, so they are
  // valid in the same cycle the state register changes.
  always_comb begin
    awready_nxt_s = (w_next_s == W_IDLE);
    wready_nxt_s  = (w_next_s == W_DATA);
    bvalid_nxt_s  = (w_next_s == W_RESP);
  end

  // Write burst bookkeeping: descriptor latch, beat count, sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_addr_r  <= 32'd0;
      w_id_r    <= 4'd0;
      w_len_r   <= 8'd0;
      w_cnt_r   <= 8'd0;
      w_size_r  <= 3'd0;
      w_burst_r <= 2'd0;
      w_err_r   <= 1'b0;
      bresp_r   <= RESP_OKAY;
    end else if (aw_fire_s) begin
      w_addr_r  <= awaddr;
      w_id_r    <= awid;
      w_len_r   <= awlen;
      w_cnt_r   <= 8'd0;
      w_size_r  <= awsize;
      w_burst_r <= awburst;
      w_err_r   <= 1'b0;
    end else if (w_fire_s) begin
      w_cnt_r  <= w_cnt_r + 8'd1;
      w_addr_r <= w_next_addr_s;
      w_err_r  <= w_err_r | w_beat_err_s;
      if (w_is_last_s) begin
        bresp_r <= (w_err_r | w_beat_err_s) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // SRAM byte-lane writes; out-of-range beats are dropped.
  always_ff @(posedge clk) begin
    if (!rst && w_fire_s && in_range(w_addr_r)) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) begin
          mem_r[word_idx(w_addr_r)][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign awready = awready_r;
  assign wready  = wready_r;
  assign bvalid  = bvalid_r;
  assign bresp   = bresp_r;
  assign bid     = w_id_r;

  // ------------------------------------------------------------- read side
  rd_state_e          r_state_r, r_next_s;
  logic [ADDR_W-1:0]  r_addr_r;
  logic [ID_W-1:0]    r_id_r;
  logic [LEN_W-1:0]   r_len_r, r_cnt_r;
  logic [SIZE_W-1:0]  r_size_r;
  logic [BURST_W-1:0] r_burst_r;
  logic [3:0]         r_lat_r;
  logic [DATA_W-1:0]  rdata_r;
  logic [RESP_W-1:0]  rresp_r;
  logic               rlast_r, arready_r, rvalid_r;
  logic               arready_nxt_s, rvalid_nxt_s;
  logic [ADDR_W-1:0]  g_addr_s, r_next_addr_s;
  logic [LEN_W-1:0]   g_len_s;
  logic [SIZE_W-1:0]  g_size_s;
  logic [BURST_W-1:0] g_burst_s;
  logic               r_illegal_s;
  logic               ar_fire_s, r_fire_s, r_is_last_s;
  logic               fetch_en_s, fetch_last_s, fetch_err_s;
  logic [ADDR_W-1:0]  fetch_addr_s;

  // While idle the generator looks at the incoming AR descriptor so that a
  // zero-latency read can classify beat 0 in the accept cycle.
  assign g_addr_s  = (r_state_r == R_IDLE) ? araddr  : r_addr_r;
  assign g_len_s   = (r_state_r == R_IDLE) ? arlen   : r_len_r;
  assign g_size_s  = (r_state_r == R_IDLE) ? arsize  : r_size_r;
  assign g_burst_s = (r_state_r == R_IDLE) ? arburst : r_burst_r;

  axi4_addr_gen u_r_addr_gen (
    .addr      (g_addr_s),
    .len       (g_len_s),
    .size      (g_size_s),
    .burst     (g_burst_s),
    .next_addr (r_next_addr_s),
    .illegal   (r_illegal_s)
  );

  assign ar_fire_s   = arvalid & arready_r;
  assign r_fire_s    = rvalid_r & rready;
  assign r_is_last_s = (r_cnt_r == r_len_r);

  // Read FSM state and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_r <= R_IDLE;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
    end else begin
      r_state_r <= r_next_s;
      arready_r <= arready_nxt_s;
      rvalid_r  <= rvalid_nxt_s;
    end
  end

  // Read FSM next-state logic.
  always_comb begin
    r_next_s = r_state_r;
    case (r_state_r)
      R_IDLE: begin
        if (ar_fire_s) r_next_s = (RD_LAT == 0) ? R_DATA : R_WAIT;
        else           r_next_s = R_IDLE;
      end
      R_WAIT: begin
        if (r_lat_r == LAT_LAST) r_next_s = R_DATA;
        else                     r_next_s = R_WAIT;
      end
      R_DATA: begin
        if (r_fire_s && r_is_last_s) r_next_s = R_IDLE;
        else                         r_next_s = R_DATA;
      end
      default: r_next_s = R_IDLE;
    endcase
  end

  // Read handshake outputs follow the state being entered.
  always_comb begin
    arready_nxt_s = (r_next_s == R_IDLE);
    rvalid_nxt_s  = (r_next_s == R_DATA);
  end

  // Select which beat (if any) is loaded into the R output registers this
  // cycle; loading only on these events keeps R stable under backpressure.
  always_comb begin
    fetch_en_s   = 1'b0;
    fetch_addr_s = r_addr_r;
    fetch_last_s = 1'b0;
    case (r_state_r)
      R_IDLE: begin
        if (ar_fire_s && (RD_LAT == 0)) begin
          fetch_en_s   = 1'b1;
          fetch_addr_s = araddr;
          fetch_last_s = (arlen == 8'd0);
        end else begin
          fetch_en_s   = 1'b0;
        end
      end
      R_WAIT: begin
        if (r_lat_r == LAT_LAST) begin
          fetch_en_s   = 1'b1;
          fetch_addr_s = r_addr_r;
          fetch_last_s = (r_len_r == 8'd0);
        end else begin
          fetch_en_s   = 1'b0;
        end
      end
      R_DATA: begin
        if (r_fire_s && !r_is_last_s) begin
          fetch_en_s   = 1'b1;
          fetch_addr_s = r_next_addr_s;
          fetch_last_s = ((r_cnt_r + 8'd1) == r_len_r);
        end else begin
          fetch_en_s   = 1'b0;
        end
      end
      default: fetch_en_s = 1'b0;
    endcase
    fetch_err_s = r_illegal_s | ~in_range(fetch_addr_s);
  end

  // Read burst bookkeeping and the R output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr_r  <= 32'd0;
      r_id_r    <= 4'd0;
      r_len_r   <= 8'd0;
      r_cnt_r   <= 8'd0;
      r_size_r  <= 3'd0;
      r_burst_r <= 2'd0;
      r_lat_r   <= 4'd0;
      rdata_r   <= 32'd0;
      rresp_r   <= RESP_OKAY;
      rlast_r   <= 1'b0;
    end else begin
      if (ar_fire_s) begin
        r_addr_r  <= araddr;
        r_id_r    <= arid;
        r_len_r   <= arlen;
        r_cnt_r   <= 8'd0;
        r_size_r  <= arsize;
        r_burst_r <= arburst;
        r_lat_r   <= 4'd0;
      end else if (r_state_r == R_WAIT) begin
        r_lat_r <= r_lat_r + 4'd1;
      end else if (r_fire_s && !r_is_last_s) begin
        r_cnt_r  <= r_cnt_r + 8'd1;
        r_addr_r <= r_next_addr_s;
      end
      // Memory read sees pre-write contents: same-cycle write is an NBA.
      if (fetch_en_s) begin
        rdata_r <= in_range(fetch_addr_s) ? mem_r[word_idx(fetch_addr_s)] : 32'd0;
        rresp_r <= fetch_err_s ? RESP_SLVERR : RESP_OKAY;
        rlast_r <= fetch_last_s;
      end else if (r_fire_s && r_is_last_s) begin
        rlast_r <= 1'b0;
      end
    end
  end

  assign arready = arready_r;
  assign rvalid  = rvalid_r;
  assign rresp   = rresp_r;
  assign rdata   = rdata_r;
  assign rlast   = rlast_r;
  assign rid     = r_id_r;

endmodule

// File: tb/tb_axi4_burst_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_axi4_burst_sram_slave
// Scoreboard bench for the AXI4 burst SRAM responder. Expected B and R
// responses are derived from a local word model and queued when a request is
// issued, then popped and compared as the DUT presents each response.
// ---------------------------------------------------------------------------
module tb_axi4_burst_sram_slave;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
    logic        chk_data;
  } rexp_t;

  typedef struct {
    logic [1:0] resp;
    logic [3:0] id;
  } bexp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        awready, awvalid = 1'b0;
  logic [31:0] awaddr = 32'd0;
  logic [3:0]  awid = 4'd0;
  logic [7:0]  awlen = 8'd0;
  logic [2:0]  awsize = 3'd2;
  logic [1:0]  awburst = 2'd1;
  logic        wready, wvalid = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  wstrb = 4'd0;
  logic        wlast = 1'b0;
  logic        bready = 1'b1, bvalid;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arready, arvalid = 1'b0;
  logic [31:0] araddr = 32'd0;
  logic [3:0]  arid = 4'd0;
  logic [7:0]  arlen = 8'd0;
  logic [2:0]  arsize = 3'd2;
  logic [1:0]  arburst = 2'd1;
  logic        rready = 1'b1, rvalid;
  logic [1:0]  rresp;
  logic [31:0] rdata;
  logic        rlast;
  logic [3:0]  rid;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mdl [DEPTH];
  logic [31:0] wdat [16];
  logic [3:0]  wstb [16];
  rexp_t rq [$];
  bexp_t bq [$];

  axi4_burst_sram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .awready(awready), .awvalid(awvalid), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wready(wready), .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bready(bready), .bvalid(bvalid), .bresp(bresp), .bid(bid),
    .arready(arready), .arvalid(arvalid), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rready(rready), .rvalid(rvalid), .rresp(rresp), .rdata(rdata), .rlast(rlast), .rid(rid)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic in_rng(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(DEPTH * 4));
  endfunction

  function automatic logic wrap_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  function automatic logic params_bad(input logic [7:0] len, input logic [2:0] size,
                                      input logic [1:0] burst);
    return (size > 3'd2) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_ok(len));
  endfunction

  // Address of beat i, computed from the start address rather than stepwise.
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int i,
                                            input logic [7:0] len, input logic [2:0] size,
                                            input logic [1:0] burst);
    logic [31:0] bytes, bound, lower;
    bytes = 32'd1 << size;
    if (burst == 2'b00) begin
      return start;
    end else if (burst == 2'b10) begin
      bound = (32'(len) + 32'd1) * bytes;
      lower = start - (start % bound);
      return lower + ((start - lower + 32'(i) * bytes) % bound);
    end else begin
      return start + 32'(i) * bytes;
    end
  endfunction

  task automatic write_burst(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                             input logic [1:0] burst, input logic bad_last);
    logic err;
    logic [31:0] a;
    bexp_t e;
    int g;
    err = params_bad(len, 3'd2, burst) || (bad_last && (len != 8'd0));
    for (int i = 0; i <= int'(len); i++) begin
      if (!in_rng(beat_addr(addr, i, len, 3'd2, burst))) err = 1'b1;
    end
    e.resp = err ? 2'b10 : 2'b00;
    e.id   = id;
    bq.push_back(e);
    @(posedge clk); #1;
    awvalid = 1'b1; awaddr = addr; awid = id; awlen = len; awsize = 3'd2; awburst = burst;
    g = 0;
    do begin @(negedge clk); g++; end while (!awready && g < 100);
    if (!awready) check_eq("aw_timeout", {63'd0, awready}, 64'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wdata = wdat[i]; wstrb = wstb[i];
      wlast = bad_last ? 1'b1 : (i == int'(len));
      g = 0;
      do begin @(negedge clk); g++; end while (!wready && g < 100);
      if (!wready) check_eq("w_timeout", {63'd0, wready}, 64'd1);
      a = beat_addr(addr, i, len, 3'd2, burst);
      if (in_rng(a)) begin
        for (int b = 0; b < 4; b++) begin
          if (wstb[i][b]) mdl[(a - BASE) >> 2][8*b +: 8] = wdat[i][8*b +: 8];
        end
      end
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    g = 0;
    while (!bvalid && g < 100) begin @(negedge clk); g++; end
    if (bvalid) begin
      e = bq.pop_front();
      check_eq("bid", {60'd0, bid}, {60'd0, e.id});
      check_eq("bresp", {62'd0, bresp}, {62'd0, e.resp});
    end else begin
      check_eq("b_timeout", {63'd0, bvalid}, 64'd1);
      bq.delete();
    end
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [1:0] burst, input int stall_at);
    logic [31:0] a;
    rexp_t e;
    int g, beat;
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, i, len, 3'd2, burst);
      e.data     = in_rng(a) ? mdl[(a - BASE) >> 2] : 32'd0;
      e.resp     = (params_bad(len, 3'd2, burst) || !in_rng(a)) ? 2'b10 : 2'b00;
      e.last     = (i == int'(len));
      e.id       = id;
      e.chk_data = !((burst == 2'b10) && !wrap_ok(len));
      rq.push_back(e);
    end
    @(posedge clk); #1;
    arvalid = 1'b1; araddr = addr; arid = id; arlen = len; arsize = 3'd2; arburst = burst;
    rready = 1'b1;
    g = 0;
    do begin @(negedge clk); g++; end while (!arready && g < 100);
    if (!arready) check_eq("ar_timeout", {63'd0, arready}, 64'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    beat = 0;
    g = 0;
    while (rq.size() > 0 && g < 300) begin
      @(negedge clk); g++;
      if (rvalid && rready) begin
        e = rq.pop_front();
        if (e.chk_data) check_eq("rdata", {32'd0, rdata}, {32'd0, e.data});
        check_eq("rresp", {62'd0, rresp}, {62'd0, e.resp});
        check_eq("rlast", {63'd0, rlast}, {63'd0, e.last});
        check_eq("rid", {60'd0, rid}, {60'd0, e.id});
        beat++;
        if (beat == stall_at && rq.size() > 0) begin
          @(posedge clk); #1;
          rready = 1'b0;
          repeat (5) begin
            @(negedge clk);
            check_eq("stall_rvalid", {63'd0, rvalid}, 64'd1);
            check_eq("stall_rdata", {32'd0, rdata}, {32'd0, rq[0].data});
            check_eq("stall_rlast", {63'd0, rlast}, {63'd0, rq[0].last});
          end
          @(posedge clk); #1;
          rready = 1'b1;
        end
      end
    end
    check_eq("r_pending", 64'(rq.size()), 64'd0);
    rq.delete();
    @(negedge clk);
    check_eq("r_extra", {63'd0, rvalid}, 64'd0);
  endtask

  initial begin
    int g;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'd0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", {61'd0, awready, arready, wready}, 64'd0);
    check_eq("rst_valid", {61'd0, bvalid, rvalid, rlast}, 64'd0);
    check_eq("rst_resp_id", {52'd0, bresp, rresp, bid, rid}, 64'd0);
    check_eq("rst_rdata", {32'd0, rdata}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("post_rst_ready", {62'd0, awready, arready}, 64'd3);

    // Single beat write/read.
    wdat[0] = 32'hDEAD_BEEF; wstb[0] = 4'hF;
    write_burst(BASE + 32'h10, 4'd3, 8'd0, 2'b01, 1'b0);
    read_burst(BASE + 32'h10, 4'd3, 8'd0, 2'b01, -1);

    // INCR len3 write and read.
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'(i + 1); wstb[i] = 4'hF; end
    write_burst(BASE, 4'd5, 8'd3, 2'b01, 1'b0);
    read_burst(BASE, 4'd6, 8'd3, 2'b01, -1);

    // WRAP: legal len3 from 0x08, illegal len2.
    read_burst(BASE + 32'h08, 4'd7, 8'd3, 2'b10, -1);
    read_burst(BASE + 32'h08, 4'd8, 8'd2, 2'b10, -1);
    // Reserved burst type behaves as INCR but flags SLVERR; FIXED repeats.
    read_burst(BASE, 4'd9, 8'd1, 2'b11, -1);
    read_burst(BASE + 32'h10, 4'd1, 8'd2, 2'b00, -1);

    // Byte strobes.
    wdat[0] = 32'hFFFF_FFFF; wstb[0] = 4'hF;
    write_burst(BASE + 32'h20, 4'd2, 8'd0, 2'b01, 1'b0);
    wdat[0] = 32'h0000_AAAA; wstb[0] = 4'h3;
    write_burst(BASE + 32'h20, 4'd2, 8'd0, 2'b01, 1'b0);
    read_burst(BASE + 32'h20, 4'd2, 8'd0, 2'b01, -1);
    check_eq("strobe_model", {32'd0, mdl[8]}, {32'd0, 32'hFFFF_AAAA});

    // Backpressure on beat 2 of a 4-beat read.
    read_burst(BASE, 4'd4, 8'd3, 2'b01, 1);

    // Error cases: out-of-range read and write, wlast mismatch.
    read_burst(BASE + 32'(DEPTH * 4), 4'd10, 8'd0, 2'b01, -1);
    wdat[0] = 32'h1234_5678; wstb[0] = 4'hF;
    write_burst(BASE - 32'd4, 4'd11, 8'd0, 2'b01, 1'b0);
    wdat[0] = 32'hA5A5_0001; wdat[1] = 32'hA5A5_0002; wstb[0] = 4'hF; wstb[1] = 4'hF;
    write_burst(BASE + 32'h80, 4'd12, 8'd1, 2'b01, 1'b1);
    read_burst(BASE + 32'h80, 4'd12, 8'd1, 2'b01, -1);

    // Reset in the middle of a write burst.
    @(posedge clk); #1;
    awvalid = 1'b1; awaddr = BASE + 32'h40; awid = 4'd13; awlen = 8'd3; awburst = 2'b01;
    g = 0;
    do begin @(negedge clk); g++; end while (!awready && g < 100);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b1; wdata = 32'h1111_1111; wstrb = 4'hF; wlast = 1'b0;
    g = 0;
    do begin @(negedge clk); g++; end while (!wready && g < 100);
    check_eq("rst_mid_wready", {63'd0, wready}, 64'd1);
    mdl[16] = 32'h1111_1111;
    @(posedge clk); #1;
    wvalid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check_eq("rst_mid_no_bvalid", {63'd0, bvalid}, 64'd0);
    end
    check_eq("rst_mid_awready", {63'd0, awready}, 64'd1);
    wdat[0] = 32'h2222_2222; wstb[0] = 4'hF;
    write_burst(BASE + 32'h44, 4'd14, 8'd0, 2'b01, 1'b0);
    read_burst(BASE + 32'h40, 4'd15, 8'd1, 2'b01, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
